inst_prefetch_queue: RTL and testbench

Instruction prefetch buffer between the memory arbiter's instruction master port and decode. Issues sequential fetch requests whenever it has free space, stores returned 32-bit instructions with their PCs in a small FIFO, and presents them to decode with a valid/ready handshake. This hides arbiter stalls caused by load/store traffic. A redirect input from the branch/jump path flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_prefetch_queue_pkg.sv | 29 ++
 rtl/inst_prefetch_queue_if.sv | 34 +++
 rtl/inst_prefetch_queue_sync_fifo_flush.sv | 82 ++++++++
 rtl/inst_prefetch_queue.sv | 84 ++++++++
 tb/tb_inst_prefetch_queue.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: datapath widths,
// the NOP encoding presented to decode when empty, the default reset PC,
// the layout of a queued entry, and the small helpers used on the fetch path.
package inst_prefetch_queue_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

   // One queued instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

   // The bus returns a 64-bit beat; the fetch address bit 2 picks the word.
   function automatic logic [ILEN-1:0] selectWord(input logic [XLEN-1:0] rdata,
                                                  input logic            upperHalf);
      return upperHalf ? rdata[63:32] : rdata[31:0];
   endfunction

   // Instructions are word aligned, so the two low address bits are dropped.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
      return pc & ~64'h3;
   endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bundle of the fetch-bus, redirect and decode-side signals of the prefetch
// queue. The master side is the prefetch queue itself; the slave side is the
// surrounding arbiter/decode/branch logic (or a testbench).
interface inst_prefetch_queue_if
   import inst_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) ();

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             HTRANS;
   logic [XLEN-1:0]  HADDR;
   logic             HGRANT;
   logic [XLEN-1:0]  HRDATA;
   logic             inst_valid;
   logic [ILEN-1:0]  inst;
   logic [XLEN-1:0]  inst_pc;
   logic             inst_ready;
   logic [CNT_W-1:0] occupancy;

   modport master (
      input  redirect_valid, redirect_pc, HGRANT, HRDATA, inst_ready,
      output HTRANS, HADDR, inst_valid, inst, inst_pc, occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc, HGRANT, HRDATA, inst_ready,
      input  HTRANS, HADDR, inst_valid, inst, inst_pc, occupancy
   );

endinterface

// File: rtl/inst_prefetch_queue_sync_fifo_flush.sv
// Synchronous FIFO with a single-cycle flush. Full/empty come from the entry
// count; pointers are log2(DEPTH) bits and wrap on their own. Flush wins over
// push and pop in the same cycle. Head data is read straight from storage,
// so it is stable for as long as the head is not popped.
module sync_fifo_flush #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] storage_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = storage_q[rdPtr_q];

   // Requests that would overflow or underflow are dropped, as is anything
   // arriving in a flush cycle.
   assign doPush = push_i && !full_o && !flush_i;
   assign doPop  = pop_i && !empty_o && !flush_i;

   // Next pointer and count values: flush clears, otherwise advance per request.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
         if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
         case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers, cleared asynchronously by the active-low reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful where the count says so.
   always_ff @(posedge CLK) begin
      if (doPush) storage_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue. Requests sequential words from the arbiter
// whenever there is room, queues each returned instruction with its PC, and
// hands them to decode over a valid/ready handshake. A redirect empties the
// queue and restarts fetching at the new PC on the following cycle.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   CLK,
   input  logic                   RESET,
   inst_prefetch_queue_if.master  bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [XLEN-1:0]  fetchPc_q, fetchPc_d;
   logic             fetchReq;
   logic             doPush;
   logic             doPop;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [CNT_W-1:0] fifoCount;
   fetch_entry_t     pushEntry;
   fetch_entry_t     headEntry;

   // The request depends only on registered state and the redirect input, so
   // decode's ready never reaches the bus.
   assign fetchReq = !fifoFull && !bus.redirect_valid;
   assign doPush   = fetchReq && bus.HGRANT;
   assign doPop    = !fifoEmpty && bus.inst_ready;

   // Capture the granted beat, picking the word that matches the fetch PC.
   always_comb begin
      pushEntry      = '0;
      pushEntry.pc   = fetchPc_q;
      pushEntry.inst = selectWord(bus.HRDATA, fetchPc_q[2]);
   end

   sync_fifo_flush #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (doPush),
      .pop_i   (doPop),
      .flush_i (bus.redirect_valid),
      .wdata_i (pushEntry),
      .rdata_o (headEntry),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // Next fetch PC: a redirect jumps to the aligned target, a granted fetch
   // steps to the next word (wrapping at the top of the address space).
   always_comb begin
      fetchPc_d = fetchPc_q;
      if (bus.redirect_valid) begin
         fetchPc_d = alignPc(bus.redirect_pc);
      end else if (doPush) begin
         fetchPc_d = fetchPc_q + 64'd4;
      end
   end

   // Fetch PC register, returned to the reset PC asynchronously.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fetchPc_q <= RESET_PC;
      end else begin
         fetchPc_q <= fetchPc_d;
      end
   end

   assign bus.HTRANS     = fetchReq;
   assign bus.HADDR      = fetchPc_q;
   assign bus.inst_valid = !fifoEmpty;
   assign bus.inst       = fifoEmpty ? INST_NOP : headEntry.inst;
   assign bus.inst_pc    = fifoEmpty ? '0 : headEntry.pc;
   assign bus.occupancy  = fifoCount;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue. A reference queue of expected
// {pc, inst} records is filled when a granted fetch is driven and consumed
// when decode accepts the head. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, well clear of the rising edge.
module tb_inst_prefetch_queue;
   import inst_prefetch_queue_pkg::*;

   localparam int              DEPTH  = 4;
   localparam logic [XLEN-1:0] RST_PC = 64'h0;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   inst_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

   inst_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   typedef struct {
      logic        grant;
      logic        ready;
      logic [63:0] expOcc;
      logic        expHtrans;
      logic [63:0] expHaddr;
      logic        expValid;
      logic [63:0] expPc;
   } vec_t;

   exp_t        sbQueue[$];
   vec_t        vecs[13];
   logic [63:0] modelPc;
   logic        curRedir;
   logic [63:0] curRpc;
   logic        curGrant;
   logic        curReady;
   int          testsRun    = 0;
   int          testsFailed = 0;

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then settle before checks.
   task automatic applyStimulus(input logic redir, input logic [63:0] rpc,
                                input logic grant, input logic ready);
      @(negedge CLK);
      curRedir = redir;
      curRpc   = rpc;
      curGrant = grant;
      curReady = ready;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.HGRANT         = grant;
      bus.inst_ready     = ready;
      bus.HRDATA         = {$urandom, $urandom};
      #1;
   endtask

   // Compare every output with the reference state for the current cycle.
   task automatic checkOutput();
      logic expHtrans;
      expHtrans = (sbQueue.size() != DEPTH) && !curRedir;
      check("inst_valid", 64'(bus.inst_valid), 64'(sbQueue.size() != 0));
      check("occupancy", 64'(bus.occupancy), 64'(sbQueue.size()));
      check("HTRANS", 64'(bus.HTRANS), 64'(expHtrans));
      check("HADDR", bus.HADDR, modelPc);
      if (sbQueue.size() != 0) begin
         check("inst", 64'(bus.inst), 64'(sbQueue[0].inst));
         check("inst_pc", bus.inst_pc, sbQueue[0].pc);
      end else begin
         check("inst_empty", 64'(bus.inst), 64'(32'h0000_0013));
         check("inst_pc_empty", bus.inst_pc, 64'h0);
      end
   endtask

   // Move the reference state across the coming rising edge.
   task automatic advanceModel();
      logic  expPush;
      exp_t  e;
      expPush = (sbQueue.size() != DEPTH) && !curRedir && curGrant;
      if (curRedir) begin
         sbQueue.delete();
         modelPc = curRpc & ~64'h3;
      end else begin
         if (sbQueue.size() != 0 && curReady) void'(sbQueue.pop_front());
         if (expPush) begin
            e.pc   = modelPc;
            e.inst = modelPc[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
            sbQueue.push_back(e);
            modelPc = modelPc + 64'd4;
         end
      end
   endtask

   task automatic runCycle(input logic redir, input logic [63:0] rpc,
                           input logic grant, input logic ready);
      applyStimulus(redir, rpc, grant, ready);
      checkOutput();
      advanceModel();
   endtask

   // Hold reset across a rising edge with idle inputs, then release it.
   task automatic holdAndReleaseReset();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.HGRANT         = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.HRDATA         = '0;
      sbQueue.delete();
      modelPc = RST_PC;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      RESET              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.HGRANT         = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.HRDATA         = '0;
      curRedir = 1'b0; curRpc = '0; curGrant = 1'b0; curReady = 1'b0;
      modelPc  = RST_PC;

      // Fill with ready low until full, then drain, then resume fetching.
      vecs[0]  = '{1'b1, 1'b0, 64'd0, 1'b1, 64'h00, 1'b0, 64'h0};
      vecs[1]  = '{1'b1, 1'b0, 64'd1, 1'b1, 64'h04, 1'b1, 64'h0};
      vecs[2]  = '{1'b1, 1'b0, 64'd2, 1'b1, 64'h08, 1'b1, 64'h0};
      vecs[3]  = '{1'b1, 1'b0, 64'd3, 1'b1, 64'h0C, 1'b1, 64'h0};
      vecs[4]  = '{1'b1, 1'b0, 64'd4, 1'b0, 64'h10, 1'b1, 64'h0};
      vecs[5]  = '{1'b1, 1'b0, 64'd4, 1'b0, 64'h10, 1'b1, 64'h0};
      vecs[6]  = '{1'b0, 1'b1, 64'd4, 1'b0, 64'h10, 1'b1, 64'h0};
      vecs[7]  = '{1'b0, 1'b1, 64'd3, 1'b1, 64'h10, 1'b1, 64'h4};
      vecs[8]  = '{1'b0, 1'b1, 64'd2, 1'b1, 64'h10, 1'b1, 64'h8};
      vecs[9]  = '{1'b0, 1'b1, 64'd1, 1'b1, 64'h10, 1'b1, 64'hC};
      vecs[10] = '{1'b1, 1'b0, 64'd0, 1'b1, 64'h10, 1'b0, 64'h0};
      vecs[11] = '{1'b0, 1'b1, 64'd1, 1'b1, 64'h14, 1'b1, 64'h10};
      vecs[12] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'h14, 1'b0, 64'h0};

      // Reset values while reset is held.
      repeat (2) @(negedge CLK);
      #1;
      check("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
      check("rst_inst", 64'(bus.inst), 64'(32'h0000_0013));
      check("rst_inst_pc", bus.inst_pc, 64'h0);
      check("rst_occupancy", 64'(bus.occupancy), 64'h0);
      check("rst_HADDR", bus.HADDR, RST_PC);
      holdAndReleaseReset();

      // Table-driven fill/drain.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, 64'h0, vecs[i].grant, vecs[i].ready);
         check($sformatf("vec%0d_occupancy", i), 64'(bus.occupancy), vecs[i].expOcc);
         check($sformatf("vec%0d_HTRANS", i), 64'(bus.HTRANS), 64'(vecs[i].expHtrans));
         check($sformatf("vec%0d_HADDR", i), bus.HADDR, vecs[i].expHaddr);
         check($sformatf("vec%0d_inst_valid", i), 64'(bus.inst_valid), 64'(vecs[i].expValid));
         check($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].expPc);
         checkOutput();
         advanceModel();
      end

      // Steady state from reset: one instruction per cycle, occupancy 1.
      @(negedge CLK);
      RESET = 1'b0;
      holdAndReleaseReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
         if (i > 0) begin
            check("steady_occupancy", 64'(bus.occupancy), 64'd1);
            check("steady_inst_pc", bus.inst_pc, 64'(4 * (i - 1)));
         end
         checkOutput();
         advanceModel();
      end

      // Alternating grant with decode always ready.
      for (int i = 0; i < 8; i++) runCycle(1'b0, 64'h0, (i % 2) == 0, 1'b1);

      // Redirect with three entries queued; target low bits are dropped.
      for (int n = 0; n < 10 && sbQueue.size() < 3; n++) runCycle(1'b0, 64'h0, 1'b1, 1'b0);
      check("redir_setup_occupancy", 64'(sbQueue.size()), 64'd3);
      runCycle(1'b1, 64'h1003, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
      check("redir_inst_valid", 64'(bus.inst_valid), 64'h0);
      check("redir_occupancy", 64'(bus.occupancy), 64'h0);
      check("redir_HADDR", bus.HADDR, 64'h1000);
      check("redir_HTRANS", 64'(bus.HTRANS), 64'h1);
      checkOutput();
      advanceModel();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
      check("redir_first_pc", bus.inst_pc, 64'h1000);
      checkOutput();
      advanceModel();

      // Redirect, grant and ready together: nothing pushed or popped.
      runCycle(1'b0, 64'h0, 1'b1, 1'b0);
      runCycle(1'b0, 64'h0, 1'b1, 1'b0);
      runCycle(1'b1, 64'h2000, 1'b1, 1'b1);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
      check("simul_occupancy", 64'(bus.occupancy), 64'h0);
      check("simul_inst_valid", 64'(bus.inst_valid), 64'h0);
      check("simul_HADDR", bus.HADDR, 64'h2000);
      checkOutput();
      advanceModel();

      // Back-to-back redirects: the last target wins.
      runCycle(1'b1, 64'h3000, 1'b1, 1'b0);
      runCycle(1'b1, 64'h4006, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
      check("b2b_HADDR", bus.HADDR, 64'h4004);
      checkOutput();
      advanceModel();
      runCycle(1'b0, 64'h0, 1'b1, 1'b1);
      runCycle(1'b0, 64'h0, 1'b0, 1'b1);

      // Fetch PC wraps at the top of the address space.
      runCycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) runCycle(1'b0, 64'h0, 1'b1, 1'b1);

      // Asynchronous reset in the middle of a fill.
      @(negedge CLK);
      RESET = 1'b0;
      holdAndReleaseReset();
      runCycle(1'b0, 64'h0, 1'b1, 1'b0);
      runCycle(1'b0, 64'h0, 1'b1, 1'b0);
      @(posedge CLK);
      #2;
      check("midfill_occupancy", 64'(bus.occupancy), 64'd2);
      check("midfill_HADDR", bus.HADDR, 64'h8);
      RESET = 1'b0;
      #1;
      check("async_inst_valid", 64'(bus.inst_valid), 64'h0);
      check("async_inst", 64'(bus.inst), 64'(32'h0000_0013));
      check("async_inst_pc", bus.inst_pc, 64'h0);
      check("async_occupancy", 64'(bus.occupancy), 64'h0);
      check("async_HADDR", bus.HADDR, RST_PC);
      holdAndReleaseReset();
      for (int i = 0; i < 4; i++) runCycle(1'b0, 64'h0, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
